// File: rtl/parking_pkg.sv
// Purpose: shared types and defaults for the parking-lot occupancy and display stages.
// Latency: n/a (types, constants and a constant-only helper).
// Backpressure: n/a.
package parking_pkg;

    // Entry-barrier FSM encoding.
    typedef enum logic {
        CERRADA = 1'b0,
        ABIERTA = 1'b1
    } barrier_state_t;

    // Defaults shared with the display stage.
    localparam int CAPACIDAD_DEF   = 20;
    localparam int OPEN_CYCLES_DEF = 50;

    // Elaboration-time BCD of a constant 0..99, used for reset values only.
    function automatic logic [7:0] bcd_const(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/parking_occupancy_counter_bin2bcd_2dig.sv
// Purpose: combinational 7-bit binary (0..99) to two BCD digits.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
//
// Ports:
//   bin  in  7  binary value, 0..99 (values above 99 are out of range)
//   bcd  out 8  [7:4] tens digit, [3:0] units digit
module bin2bcd_2dig (
    input  logic [6:0] bin,
    output logic [7:0] bcd
);

    logic [3:0] tens;
    logic [3:0] units;

    // Ascending threshold scan: the last threshold that bin reaches wins,
    // which yields the tens digit without a divider.
    always_comb begin
        tens  = 4'd0;
        units = bin[3:0];
        for (int i = 1; i <= 9; i++) begin
            if (bin >= 7'(10 * i)) begin
                tens  = 4'(i);
                units = 4'(bin - 7'(10 * i));
            end
        end
    end

    assign bcd = {tens, units};

endmodule

// File: rtl/parking_occupancy_counter.sv
// Purpose: lot occupancy/free counters, full/empty flags, reject/underflow pulses, timed entry barrier.
// Latency: 1 cycle; an input pulse sampled at edge N is reflected on every output after edge N.
// Backpressure: none; every pulse is consumed, an entry while full is rejected (rechazo) and an exit while empty is flagged (error_salida).
//
// Ports:
//   clk           in   1      rising-edge clock
//   reset_n       in   1      asynchronous active-low reset
//   entrada       in   1      1-cycle pulse, a vehicle completed entry
//   salida        in   1      1-cycle pulse, a vehicle completed exit
//   ocupados      out  CNT_W  occupied spaces
//   libres        out  CNT_W  free spaces (CAPACIDAD - ocupados)
//   libres_bcd    out  8      free spaces as two BCD digits
//   lleno         out  1      ocupados == CAPACIDAD
//   vacio         out  1      ocupados == 0
//   rechazo       out  1      1-cycle pulse, entry arrived while full
//   error_salida  out  1      1-cycle pulse, exit arrived while empty
//   barrera       out  1      entry barrier open command
module parking_occupancy_counter
    import parking_pkg::*;
#(
    parameter int CAPACIDAD   = CAPACIDAD_DEF,
    parameter int OPEN_CYCLES = OPEN_CYCLES_DEF,
    parameter int CNT_W       = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             entrada,
    input  logic             salida,
    output logic [CNT_W-1:0] ocupados,
    output logic [CNT_W-1:0] libres,
    output logic [7:0]       libres_bcd,
    output logic             lleno,
    output logic             vacio,
    output logic             rechazo,
    output logic             error_salida,
    output logic             barrera
);

    localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACIDAD);
    localparam logic [15:0]      T_LOAD  = 16'(OPEN_CYCLES - 1);
    localparam logic [7:0]       BCD_RST = bcd_const(CAPACIDAD);

    // ------------------------------------------------------------------
    // Event decode. Simultaneous entry and exit cancel each other.
    // ------------------------------------------------------------------
    logic ent_only, sal_only;
    logic full_now, empty_now;
    logic accept, reject, dec, underflow;

    assign ent_only  = entrada & ~salida;
    assign sal_only  = salida & ~entrada;
    assign full_now  = (ocupados == CAP);
    assign empty_now = (ocupados == '0);
    assign accept    = ent_only & ~full_now;
    assign reject    = ent_only & full_now;
    assign dec       = sal_only & ~empty_now;
    assign underflow = sal_only & empty_now;

    // ------------------------------------------------------------------
    // Next-state count; every derived output is computed from it so the
    // registered values are mutually consistent in the same cycle.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] ocup_nxt;
    logic [CNT_W-1:0] libres_nxt;
    logic [7:0]       bcd_nxt;

    always_comb begin
        ocup_nxt = ocupados;
        if (accept) begin
            ocup_nxt = ocupados + CNT_W'(1);
        end else if (dec) begin
            ocup_nxt = ocupados - CNT_W'(1);
        end
    end

    assign libres_nxt = CAP - ocup_nxt;

    bin2bcd_2dig u_bin2bcd (
        .bin (7'(libres_nxt)),
        .bcd (bcd_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ocupados     <= '0;
            libres       <= CAP;
            libres_bcd   <= BCD_RST;
            lleno        <= 1'b0;
            vacio        <= 1'b1;
            rechazo      <= 1'b0;
            error_salida <= 1'b0;
        end else begin
            ocupados     <= ocup_nxt;
            libres       <= libres_nxt;
            libres_bcd   <= bcd_nxt;
            lleno        <= (ocup_nxt == CAP);
            vacio        <= (ocup_nxt == '0);
            rechazo      <= reject;
            error_salida <= underflow;
        end
    end

    // ------------------------------------------------------------------
    // Barrier FSM. The timer holds the number of further open cycles
    // after the current one; an accepted entry reloads it in either state.
    // ------------------------------------------------------------------
    barrier_state_t state, state_nxt;
    logic [15:0]    timer, timer_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CERRADA;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            CERRADA: begin
                if (accept) begin
                    state_nxt = ABIERTA;
                    timer_nxt = T_LOAD;
                end
            end
            ABIERTA: begin
                if (accept) begin
                    timer_nxt = T_LOAD;
                end else if (timer == '0) begin
                    state_nxt = CERRADA;
                end else begin
                    timer_nxt = timer - 16'd1;
                end
            end
            default: begin
                state_nxt = CERRADA;
                timer_nxt = '0;
            end
        endcase
    end

    // state is a flop, so barrera is a registered output.
    assign barrera = (state == ABIERTA);

endmodule

// File: tb/tb_parking_occupancy_counter.sv
module tb_parking_occupancy_counter;

    localparam int CAP  = 3;
    localparam int OPEN = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic entrada = 1'b0;
    logic salida = 1'b0;

    logic [6:0] ocupados, libres;
    logic [7:0] libres_bcd;
    logic       lleno, vacio, rechazo, error_salida, barrera;

    // Second instance at the default-style capacity for the two-digit BCD case.
    logic       e20 = 1'b0;
    logic [6:0] ocup20, lib20;
    logic [7:0] bcd20;
    logic       lleno20, vacio20, rech20, err20, bar20;

    always #5 clk = ~clk;

    parking_occupancy_counter #(.CAPACIDAD(CAP), .OPEN_CYCLES(OPEN), .CNT_W(7)) dut (
        .clk(clk), .reset_n(reset_n), .entrada(entrada), .salida(salida),
        .ocupados(ocupados), .libres(libres), .libres_bcd(libres_bcd),
        .lleno(lleno), .vacio(vacio), .rechazo(rechazo),
        .error_salida(error_salida), .barrera(barrera)
    );

    parking_occupancy_counter #(.CAPACIDAD(20), .OPEN_CYCLES(OPEN), .CNT_W(7)) dut20 (
        .clk(clk), .reset_n(reset_n), .entrada(e20), .salida(1'b0),
        .ocupados(ocup20), .libres(lib20), .libres_bcd(bcd20),
        .lleno(lleno20), .vacio(vacio20), .rechazo(rech20),
        .error_salida(err20), .barrera(bar20)
    );

    typedef struct packed {
        logic [6:0] occ;
        logic [6:0] lib;
        logic [7:0] bcd;
        logic       lle;
        logic       vac;
        logic       rec;
        logic       err;
        logic       bar;
    } obs_t;

    int errors = 0;
    int checks = 0;
    obs_t q[$];

    // Reference model state: occupancy and remaining barrier-open cycles.
    int m_occ = 0;
    int m_rem = 0;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic obs_t sample();
        return {ocupados, libres, libres_bcd, lleno, vacio, rechazo, error_salida, barrera};
    endfunction

    // Drive one cycle of stimulus and push the model's expected outputs.
    task automatic drive(input logic e, input logic s);
        logic rec, err, acc;
        obs_t exp;
        rec = 1'b0; err = 1'b0; acc = 1'b0;
        if (e && !s) begin
            if (m_occ == CAP) rec = 1'b1;
            else begin m_occ++; acc = 1'b1; end
        end else if (s && !e) begin
            if (m_occ == 0) err = 1'b1;
            else m_occ--;
        end
        if (acc) m_rem = OPEN;
        else if (m_rem > 0) m_rem--;
        exp.occ = 7'(m_occ);
        exp.lib = 7'(CAP - m_occ);
        exp.bcd = to_bcd(CAP - m_occ);
        exp.lle = (m_occ == CAP);
        exp.vac = (m_occ == 0);
        exp.rec = rec;
        exp.err = err;
        exp.bar = (m_rem > 0);
        q.push_back(exp);
        entrada = e;
        salida  = s;
        @(posedge clk);
        #1;
        entrada = 1'b0;
        salida  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_occ = 0;
        m_rem = 0;
        q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b1, 1'b0); void'(q.pop_front());
        drive(1'b1, 1'b0); void'(q.pop_front());
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (ocupados !== 7'd0) begin errors++; $display("FAIL reset_ocupados got=%0d want=0", ocupados); end
        checks++; if (libres !== 7'd3) begin errors++; $display("FAIL reset_libres got=%0d want=3", libres); end
        checks++; if (libres_bcd !== 8'h03) begin errors++; $display("FAIL reset_bcd got=%h want=03", libres_bcd); end
        checks++; if (vacio !== 1'b1 || lleno !== 1'b0) begin errors++; $display("FAIL reset_flags got vacio=%b lleno=%b want 1/0", vacio, lleno); end
        checks++; if (barrera !== 1'b0 || rechazo !== 1'b0 || error_salida !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got bar=%b rech=%b err=%b want 0/0/0", barrera, rechazo, error_salida); end
        @(negedge clk);
        reset_n = 1'b1;
        m_occ = 0; m_rem = 0; q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_entry();
        obs_t exp, got;
        int hi;
        hi = 0;
        do_reset();
        drive(1'b1, 1'b0);
        checks++; if (ocupados !== 7'd1 || libres !== 7'd2 || vacio !== 1'b0) begin
            errors++; $display("FAIL single_counts got occ=%0d lib=%0d vac=%b want 1/2/0", ocupados, libres, vacio); end
        for (int i = 0; i < 7; i++) begin
            if (i > 0) drive(1'b0, 1'b0);
            exp = q.pop_front(); got = sample();
            if (got.bar) hi++;
            checks++; if (got !== exp) begin errors++; $display("FAIL single_cyc%0d got=%h want=%h", i, got, exp); end
        end
        checks++; if (hi != OPEN) begin errors++; $display("FAIL single_barrier_len got=%0d want=%0d", hi, OPEN); end
    endtask

    task automatic test_fill_reject();
        obs_t exp, got;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            exp = q.pop_front(); got = sample();
            checks++; if (got !== exp) begin errors++; $display("FAIL fill_%0d got=%h want=%h", i, got, exp); end
        end
        checks++; if (lleno !== 1'b1 || ocupados !== 7'd3) begin
            errors++; $display("FAIL fill_full got lleno=%b occ=%0d want 1/3", lleno, ocupados); end
        drive(1'b0, 1'b0); void'(q.pop_front());
        drive(1'b1, 1'b0);
        exp = q.pop_front(); got = sample();
        checks++; if (rechazo !== 1'b1 || ocupados !== 7'd3) begin
            errors++; $display("FAIL reject_pulse got rech=%b occ=%0d want 1/3", rechazo, ocupados); end
        checks++; if (got !== exp) begin errors++; $display("FAIL reject_state got=%h want=%h", got, exp); end
        // Barrier must close on the original schedule, not a reloaded one.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0);
            exp = q.pop_front(); got = sample();
            checks++; if (got !== exp) begin errors++; $display("FAIL reject_after%0d got=%h want=%h", i, got, exp); end
        end
    endtask

    task automatic test_drain_underflow();
        obs_t exp, got;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1);
            exp = q.pop_front(); got = sample();
            checks++; if (got !== exp) begin errors++; $display("FAIL drain_%0d got=%h want=%h", i, got, exp); end
        end
        checks++; if (vacio !== 1'b1 || libres_bcd !== 8'h03) begin
            errors++; $display("FAIL drain_empty got vac=%b bcd=%h want 1/03", vacio, libres_bcd); end
        drive(1'b0, 1'b1);
        exp = q.pop_front(); got = sample();
        checks++; if (error_salida !== 1'b1 || ocupados !== 7'd0) begin
            errors++; $display("FAIL underflow got err=%b occ=%0d want 1/0", error_salida, ocupados); end
        drive(1'b0, 1'b0);
        exp = q.pop_front(); got = sample();
        checks++; if (got !== exp) begin errors++; $display("FAIL underflow_clear got=%h want=%h", got, exp); end
    endtask

    task automatic test_simultaneous();
        obs_t exp, got;
        do_reset();
        drive(1'b1, 1'b0); void'(q.pop_front());
        for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b0); void'(q.pop_front()); end
        drive(1'b1, 1'b1);
        exp = q.pop_front(); got = sample();
        checks++; if (ocupados !== 7'd1 || rechazo !== 1'b0 || error_salida !== 1'b0 || barrera !== 1'b0) begin
            errors++; $display("FAIL simult got occ=%0d rech=%b err=%b bar=%b want 1/0/0/0",
                               ocupados, rechazo, error_salida, barrera); end
        checks++; if (got !== exp) begin errors++; $display("FAIL simult_model got=%h want=%h", got, exp); end
    endtask

    task automatic test_back_to_back();
        obs_t exp, got;
        int hi, run;
        hi = 0; run = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive((i == 0 || i == 2) ? 1'b1 : 1'b0, 1'b0);
            exp = q.pop_front(); got = sample();
            if (got.bar) begin run++; if (run > hi) hi = run; end else run = 0;
            checks++; if (got !== exp) begin errors++; $display("FAIL retrig_cyc%0d got=%h want=%h", i, got, exp); end
        end
        checks++; if (hi != 2 + OPEN) begin errors++; $display("FAIL retrig_len got=%0d want=%0d", hi, 2 + OPEN); end
    endtask

    task automatic test_bcd20();
        do_reset();
        checks++; if (bcd20 !== 8'h20 || lib20 !== 7'd20) begin
            errors++; $display("FAIL bcd20_reset got bcd=%h lib=%0d want 20/20", bcd20, lib20); end
        for (int k = 1; k <= 11; k++) begin
            e20 = 1'b1;
            @(posedge clk);
            #1;
            e20 = 1'b0;
            checks++; if (lib20 !== 7'(20 - k) || bcd20 !== to_bcd(20 - k)) begin
                errors++; $display("FAIL bcd20_step%0d got lib=%0d bcd=%h want %0d/%h", k, lib20, bcd20, 20 - k, to_bcd(20 - k)); end
        end
        checks++; if (lib20 !== 7'd9 || bcd20 !== 8'h09) begin
            errors++; $display("FAIL bcd20_final got lib=%0d bcd=%h want 9/09", lib20, bcd20); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single_entry();
        test_fill_reject();
        test_drain_underflow();
        test_simultaneous();
        test_back_to_back();
        test_bcd20();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
